// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its central sequencer.
// The datapath side is the master; the sequencer (pipeline_ctrl) is the slave.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             imem_resp;
    logic             mem_dmem_req;
    logic             dmem_resp;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_br_taken;
    logic             ex_muldiv;
    logic             load_pc;
    logic             load_if_id;
    logic             load_id_ex;
    logic             load_ex_mem;
    logic             load_mem_wb;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             md_start;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output imem_resp, mem_dmem_req, dmem_resp, ex_is_load, ex_rd,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_br_taken, ex_muldiv,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, md_start, md_busy, stall_cycles
    );

    modport slave (
        input  imem_resp, mem_dmem_req, dmem_resp, ex_is_load, ex_rd,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_br_taken, ex_muldiv,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, md_start, md_busy, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-stage load enables and bubble flushes for memory,
// load-use, branch and mul/div stalls, plus a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);
    localparam int unsigned CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MD_LAT - 1);

    typedef enum logic [1:0] {
        RUN,
        MD_BUSY,
        MD_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_dmem_stall;
    logic w_md_hold;
    logic w_load_use;
    logic w_freeze;
    logic w_load_pc, w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb;
    logic w_flush_if_id, w_flush_id_ex;
    logic w_md_start, w_md_busy;

    assign w_dmem_stall = bus.mem_dmem_req & ~bus.dmem_resp;
    assign w_md_hold    = ((r_state == RUN) & bus.ex_muldiv) | (r_state == MD_BUSY);
    assign w_load_use   = bus.ex_is_load & (bus.ex_rd != 5'd0) &
                          ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                           (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));
    // A taken branch with the fetch still outstanding freezes everything so the
    // PC cannot move underneath the I-side.
    assign w_freeze     = w_dmem_stall | w_md_hold | (bus.ex_br_taken & ~bus.imem_resp);

    always_comb begin
        w_load_pc     = 1'b0;
        w_load_if_id  = 1'b0;
        w_load_id_ex  = 1'b0;
        w_load_ex_mem = 1'b0;
        w_load_mem_wb = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_md_start    = 1'b0;
        w_md_busy     = 1'b0;
        w_state_next  = r_state;
        w_count_next  = r_count;

        if (!rst) begin
            if (w_freeze) begin
                w_load_pc = 1'b0;
            end else if (bus.ex_br_taken) begin
                {w_load_pc, w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb} = '1;
                w_flush_if_id = 1'b1;
                w_flush_id_ex = 1'b1;
            end else if (w_load_use) begin
                {w_load_id_ex, w_load_ex_mem, w_load_mem_wb} = '1;
                w_flush_id_ex = 1'b1;
            end else if (!bus.imem_resp) begin
                {w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb} = '1;
                w_flush_if_id = 1'b1;
            end else begin
                {w_load_pc, w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb} = '1;
            end

            unique case (r_state)
                RUN: begin
                    if (bus.ex_muldiv) begin
                        w_md_start   = 1'b1;
                        w_count_next = CNT_INIT;
                        w_state_next = (CNT_INIT == '0) ? MD_DONE : MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    w_md_busy    = 1'b1;
                    w_count_next = r_count - CW'(1);
                    if (r_count <= CW'(1)) begin
                        w_state_next = MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (w_load_ex_mem) begin
                        w_state_next = RUN;
                    end
                end
                default: w_state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_count     <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (!w_load_pc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.load_pc      = w_load_pc;
    assign bus.load_if_id   = w_load_if_id;
    assign bus.load_id_ex   = w_load_id_ex;
    assign bus.load_ex_mem  = w_load_ex_mem;
    assign bus.load_mem_wb  = w_load_mem_wb;
    assign bus.flush_if_id  = w_flush_if_id;
    assign bus.flush_id_ex  = w_flush_id_ex;
    assign bus.md_start     = w_md_start;
    assign bus.md_busy      = w_md_busy;
    assign bus.stall_cycles = rst ? '0 : r_stall_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a vector table for single-cycle priority
// decoding plus hand sequences for branch wait, mul/div timing and saturation.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(32)) if1 ();
    pipeline_ctrl_if #(.CNT_W(4))  if2 ();

    assign if2.imem_resp    = if1.imem_resp;
    assign if2.mem_dmem_req = if1.mem_dmem_req;
    assign if2.dmem_resp    = if1.dmem_resp;
    assign if2.ex_is_load   = if1.ex_is_load;
    assign if2.ex_rd        = if1.ex_rd;
    assign if2.id_rs1       = if1.id_rs1;
    assign if2.id_rs2       = if1.id_rs2;
    assign if2.id_use_rs1   = if1.id_use_rs1;
    assign if2.id_use_rs2   = if1.id_use_rs2;
    assign if2.ex_br_taken  = if1.ex_br_taken;
    assign if2.ex_muldiv    = if1.ex_muldiv;

    pipeline_ctrl #(.MD_LAT(4), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(if1));
    pipeline_ctrl #(.MD_LAT(4), .CNT_W(4))  dut_sat (.clk(clk), .rst(rst), .bus(if2));

    // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
    localparam logic [6:0] ALL_RUN  = 7'b1111100;
    localparam logic [6:0] FROZEN   = 7'b0000000;
    localparam logic [6:0] BR_FLUSH = 7'b1111111;
    localparam logic [6:0] LU_STALL = 7'b0011101;
    localparam logic [6:0] IM_MISS  = 7'b0111110;

    typedef struct {
        logic       imem, dreq, dresp, ld;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, br;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic imem, input logic dreq, input logic dresp,
                                input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2,
                                input logic br, input logic [6:0] exp);
        vec_t v;
        v.imem = imem; v.dreq = dreq; v.dresp = dresp; v.ld = ld;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.br = br;
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {if1.load_pc, if1.load_if_id, if1.load_id_ex, if1.load_ex_mem,
                if1.load_mem_wb, if1.flush_if_id, if1.flush_id_ex};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic idle();
        if1.imem_resp = 1'b1; if1.mem_dmem_req = 1'b0; if1.dmem_resp = 1'b0;
        if1.ex_is_load = 1'b0; if1.ex_rd = 5'd0; if1.id_rs1 = 5'd0; if1.id_rs2 = 5'd0;
        if1.id_use_rs1 = 1'b0; if1.id_use_rs2 = 1'b0; if1.ex_br_taken = 1'b0;
        if1.ex_muldiv = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL_RUN);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, FROZEN);
        vecs[2]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, ALL_RUN);
        vecs[3]  = mk(1, 0, 0, 1, 5, 0, 5, 0, 1, 0, LU_STALL);
        vecs[4]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, ALL_RUN);
        vecs[5]  = mk(1, 0, 0, 1, 7, 7, 0, 1, 0, 0, LU_STALL);
        vecs[6]  = mk(1, 0, 0, 1, 7, 7, 0, 0, 0, 0, ALL_RUN);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IM_MISS);
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, BR_FLUSH);
        vecs[9]  = mk(1, 0, 0, 1, 5, 0, 5, 0, 1, 1, BR_FLUSH);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FROZEN);
        vecs[11] = mk(0, 0, 0, 1, 3, 3, 0, 1, 0, 0, LU_STALL);
        vecs[12] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, FROZEN);

        // Reset with every input high: all outputs must stay low.
        if1.imem_resp = 1'b1; if1.mem_dmem_req = 1'b1; if1.dmem_resp = 1'b1;
        if1.ex_is_load = 1'b1; if1.ex_rd = '1; if1.id_rs1 = '1; if1.id_rs2 = '1;
        if1.id_use_rs1 = 1'b1; if1.id_use_rs2 = 1'b1; if1.ex_br_taken = 1'b1;
        if1.ex_muldiv = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_outs", 32'(outs()), 32'(FROZEN));
            chk("rst_md", {30'd0, if1.md_start, if1.md_busy}, 32'd0);
            chk("rst_cnt", if1.stall_cycles, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        chk("post_rst_cnt", if1.stall_cycles, 32'd0);
        chk("post_rst_outs", 32'(outs()), 32'(ALL_RUN));
        chk("post_rst_md", {30'd0, if1.md_start, if1.md_busy}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if1.imem_resp = vecs[i].imem; if1.mem_dmem_req = vecs[i].dreq;
            if1.dmem_resp = vecs[i].dresp; if1.ex_is_load = vecs[i].ld;
            if1.ex_rd = vecs[i].rd; if1.id_rs1 = vecs[i].rs1; if1.id_rs2 = vecs[i].rs2;
            if1.id_use_rs1 = vecs[i].u1; if1.id_use_rs2 = vecs[i].u2;
            if1.ex_br_taken = vecs[i].br; if1.ex_muldiv = 1'b0;
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Branch waits for the outstanding fetch.
        do_reset();
        if1.ex_br_taken = 1'b1; if1.imem_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk($sformatf("br_wait%0d", c), 32'(outs()), 32'(FROZEN));
        end
        @(negedge clk);
        if1.imem_resp = 1'b1;
        #1;
        chk("br_go", 32'(outs()), 32'(BR_FLUSH));
        chk("br_cnt", if1.stall_cycles, 32'd3);

        // Mul/div timing with ex_muldiv held high throughout.
        do_reset();
        if1.ex_muldiv = 1'b1;
        #1;
        chk("md_c0_start", 32'(if1.md_start), 32'd1);
        chk("md_c0_busy", 32'(if1.md_busy), 32'd0);
        chk("md_c0_outs", 32'(outs()), 32'(FROZEN));
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("md_c%0d_md", c), {30'd0, if1.md_start, if1.md_busy}, 32'd1);
            chk($sformatf("md_c%0d_outs", c), 32'(outs()), 32'(FROZEN));
        end
        @(negedge clk); #1;
        chk("md_c4_md", {30'd0, if1.md_start, if1.md_busy}, 32'd0);
        chk("md_c4_outs", 32'(outs()), 32'(ALL_RUN));
        @(negedge clk);
        if1.ex_muldiv = 1'b0;
        #1;
        chk("md_cnt", if1.stall_cycles, 32'd4);

        // Data-memory stall overlapping MD_DONE.
        do_reset();
        if1.ex_muldiv = 1'b1;
        repeat (4) @(negedge clk);
        if1.mem_dmem_req = 1'b1; if1.dmem_resp = 1'b0;
        #1;
        chk("mdd_stall_outs", 32'(outs()), 32'(FROZEN));
        @(negedge clk); #1;
        chk("mdd_hold_md", {30'd0, if1.md_start, if1.md_busy}, 32'd0);
        chk("mdd_hold_outs", 32'(outs()), 32'(FROZEN));
        @(negedge clk);
        if1.dmem_resp = 1'b1;
        #1;
        chk("mdd_release", 32'(outs()), 32'(ALL_RUN));
        chk("mdd_release_md", {30'd0, if1.md_start, if1.md_busy}, 32'd0);
        @(negedge clk); #1;
        chk("mdd_back_run", 32'(if1.md_start), 32'd1);

        // Reset in the middle of a mul/div.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("md_rst_md", {30'd0, if1.md_start, if1.md_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        if1.ex_muldiv = 1'b0; if1.mem_dmem_req = 1'b0;
        #1;
        chk("md_rst_run", 32'(outs()), 32'(ALL_RUN));
        chk("md_rst_busy", 32'(if1.md_busy), 32'd0);

        // Counter saturation on the 4-bit instance.
        do_reset();
        if1.imem_resp = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("sat_cnt4", 32'(if2.stall_cycles), 32'd15);
        chk("sat_cnt32", if1.stall_cycles, 32'd20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        chk("sat_rst", 32'(if2.stall_cycles), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
